// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between WRITEBACK and a FIFO of multi-cycle results
//   in : clk, rst, pipe_we/pipe_rd/pipe_data (WRITEBACK), mc_valid/mc_rd/mc_data (multi-cycle offer)
//   out: mc_ready, rf_we/rf_wa/rf_wd (write port), pipe_stall, busy_mask (registers with queued writes)
module wb_port_arbiter #(
  parameter int DEPTH = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_rd,
  input  logic [31:0] pipe_data,
  input  logic        mc_valid,
  input  logic [4:0]  mc_rd,
  input  logic [31:0] mc_data,
  output logic        mc_ready,
  output logic        rf_we,
  output logic [4:0]  rf_wa,
  output logic [31:0] rf_wd,
  output logic        pipe_stall,
  output logic [31:0] busy_mask
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [4:0]       rd_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [AW-1:0]    wp, rp;
  logic [AW:0]      cnt;
  logic [SW-1:0]    starve;
  logic             empty, full, pipe_req, pop, push;
  assign empty = cnt == '0;
  assign full = cnt == (AW+1)'(DEPTH);
  assign mc_ready = !full && !rst;
  // stall is a pure function of registered state; rst gating keeps outputs quiet during reset
  assign pipe_stall = !rst && !empty && starve == SW'(STARVE_LIMIT);
  assign pipe_req = !rst && pipe_we && pipe_rd != 5'd0 && !pipe_stall;
  assign pop = !rst && !pipe_req && !empty;
  // r0 results are accepted but never queued
  assign push = mc_valid && mc_ready && mc_rd != 5'd0;
  always_comb begin
    rf_we = pipe_req || pop;
    rf_wa = pipe_req ? pipe_rd : pop ? rd_q[rp] : 5'd0;
    rf_wd = pipe_req ? pipe_data : pop ? data_q[rp] : 32'd0;
  end
  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < DEPTH; i++)
      if (vld[i] && !rst) busy_mask[rd_q[i]] = 1'b1;
    busy_mask[0] = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      starve <= '0;
    end else begin
      if (push) begin
        rd_q[wp] <= mc_rd;
        data_q[wp] <= mc_data;
        wp <= wp + AW'(1);
      end
      if (pop) rp <= rp + AW'(1);
      // a slot can't be both pushed and popped in one cycle unless full, which blocks push
      for (int i = 0; i < DEPTH; i++)
        vld[i] <= (push && wp == AW'(i)) ? 1'b1 : (pop && rp == AW'(i)) ? 1'b0 : vld[i];
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
      starve <= (pop || empty) ? '0 : (starve == SW'(STARVE_LIMIT)) ? starve : starve + SW'(1);
    end
  end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: randomized and directed stimulus checked against a queue-based reference model
module tb_wb_port_arbiter;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;
  logic        clk = 1'b0;
  logic        rst, pipe_we, mc_valid;
  logic [4:0]  pipe_rd, mc_rd;
  logic [31:0] pipe_data, mc_data;
  logic        mc_ready, rf_we, pipe_stall;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd, busy_mask;
  int checks = 0;
  int errors = 0;
  logic [36:0] q[$];
  int starve = 0;
  wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst), .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
    .mc_valid(mc_valid), .mc_rd(mc_rd), .mc_data(mc_data), .mc_ready(mc_ready),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .pipe_stall(pipe_stall), .busy_mask(busy_mask)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask
  task automatic step(input logic r, input logic pwe, input logic [4:0] prd, input logic [31:0] pd,
                      input logic mv, input logic [4:0] mr, input logic [31:0] md);
    logic e_ready, e_stall, preq, popd, e_we;
    logic [4:0] e_wa;
    logic [31:0] e_wd, e_mask;
    int n;
    @(negedge clk);
    rst = r; pipe_we = pwe; pipe_rd = prd; pipe_data = pd;
    mc_valid = mv; mc_rd = mr; mc_data = md;
    #1;
    n = q.size();
    e_ready = !r && n < DEPTH;
    e_stall = !r && n > 0 && starve == LIMIT;
    preq = !r && pwe && prd != 0 && !e_stall;
    popd = !r && !preq && n > 0;
    e_we = preq || popd;
    e_wa = preq ? prd : popd ? q[0][36:32] : 5'd0;
    e_wd = preq ? pd : popd ? q[0][31:0] : 32'd0;
    e_mask = '0;
    if (!r) foreach (q[i]) e_mask[q[i][36:32]] = 1'b1;
    check("mc_ready", 32'(mc_ready), 32'(e_ready));
    check("pipe_stall", 32'(pipe_stall), 32'(e_stall));
    check("rf_we", 32'(rf_we), 32'(e_we));
    check("rf_wa", 32'(rf_wa), 32'(e_wa));
    check("rf_wd", rf_wd, e_wd);
    check("busy_mask", busy_mask, e_mask);
    @(posedge clk);
    if (r) begin
      q.delete();
      starve = 0;
    end else begin
      starve = (popd || n == 0) ? 0 : (starve < LIMIT ? starve + 1 : LIMIT);
      if (popd) void'(q.pop_front());
      if (mv && e_ready && mr != 0) q.push_back({mr, md});
    end
  endtask
  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    rst = 1; pipe_we = 0; pipe_rd = 0; pipe_data = 0; mc_valid = 0; mc_rd = 0; mc_data = 0;
    step(1, 0, 0, 0, 1, 5'd9, 32'h1234);
    step(1, 0, 0, 0, 1, 5'd9, 32'h1234);
    idle(1);
    step(0, 0, 0, 0, 1, 5'd5, 32'hDEADBEEF);
    idle(2);
    step(0, 1, 5'd3, 32'hA, 1, 5'd7, 32'h1);
    for (int i = 0; i < 7; i++) step(0, 1, 5'd3, 32'hA0 + i, 0, 0, 0);
    idle(2);
    for (int i = 0; i < 3; i++) step(0, 1, 5'd3, 32'hB0 + i, 1, 5'(10 + i), 32'hC0 + i);
    idle(4);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 1, 5'(20 + i), 32'hD0 + i);
      step(0, 1, 5'd4, 32'hE0, 1, 5'(25 + i), 32'hF0 + i);
      idle(2);
    end
    step(0, 0, 0, 0, 1, 5'd0, 32'h55);
    idle(1);
    step(0, 1, 5'd1, 32'h1, 1, 5'd6, 32'h66);
    step(0, 1, 5'd0, 32'h2, 0, 0, 0);
    idle(1);
    step(0, 1, 5'd2, 32'h3, 1, 5'd8, 32'h88);
    step(0, 1, 5'd2, 32'h4, 1, 5'd9, 32'h99);
    step(1, 1, 5'd2, 32'h5, 0, 0, 0);
    idle(3);
    for (int i = 0; i < 3000; i++) begin
      logic bias;
      bias = ((i / 200) % 2) == 1;
      step($urandom_range(0, 99) == 0,
           bias ? ($urandom_range(0, 9) != 0) : 1'($urandom),
           5'($urandom_range(0, 31) < 3 ? 0 : $urandom),
           $urandom,
           1'($urandom),
           5'($urandom_range(0, 31) < 3 ? 0 : $urandom),
           $urandom);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
